mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the EX/MEM register contents and completes data-memory accesses started upstream by collecting the AXI4-Lite R and B responses.
- Aligns and sign/zero-extends load data and raises load/store access-fault exceptions.
- Drives the MEM/WB pipeline register, whose rd_* outputs also feed the execute-stage bypass network.

Parameters:
- none; widths fixed by the RV32 datapath.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline flush
valid_in  in  1  EX/MEM entry valid
ready_out  out  1  entry accepted this cycle
valid_out  out  1  MEM/WB entry valid
ready_in  in  1  WB accepts entry
PC_EX, IR_EX  in  32  instruction address/word
rd_wena_EX  in  1  register write enable
rd_addr_EX  in  6  destination (bit5 = FP file)
rd_data_EX  in  32  non-memory result
wb_src_EX  in  3  writeback source (SEL_MEM = memory access)
mem_op_EX  in  3  MEM_LB/LH/LW/LBU/LHU/SB/SH/SW
addr_lsb_EX  in  2  byte offset of access address
exc_pend_EX  in  1  upstream exception pending
exc_cause_EX  in  32  upstream cause
dmem_axi_arvalid, dmem_axi_arready, dmem_axi_awvalid, dmem_axi_awready  in  1  snooped address handshakes
dmem_axi_rdata  in  32  read data
dmem_axi_rresp  in  2  read response
dmem_axi_rvalid  in  1  read data valid
dmem_axi_rready  out  1  read data ready
dmem_axi_bresp  in  2  write response
dmem_axi_bvalid  in  1  write response valid
dmem_axi_bready  out  1  write response ready
PC_MEM, IR_MEM  out  32  registered copies
rd_wena_MEM  out  1  register write enable
rd_addr_MEM  out  6  destination
rd_data_MEM  out  32  writeback/bypass data
exc_pend_MEM  out  1  exception pending
exc_cause_MEM  out  32  cause

Behaviour:
- is_ld = valid_in && wb_src_EX==SEL_MEM && rd_wena_EX && !exc_pend_EX.
- is_st = valid_in && wb_src_EX==SEL_MEM && !rd_wena_EX && !exc_pend_EX.
- Outstanding flags rd_outst/wr_outst:
  - Set on AR/AW handshake.
  - Cleared on R/B handshake.
  - At most one of each outstanding, because EX holds the access until this stage accepts it.
- Response FSM states:
  - IDLE: no captured response.
  - HELD: response captured in buffer resp_data/resp_err while ready_in=0.
  - DRAIN: flushed access awaiting its response.
- rready = (is_ld && state==IDLE) || state==DRAIN. bready is the analogous expression using is_st.
- Handshake with IDLE and ready_in=1: entry accepted the same cycle, with zero added latency.
- Handshake with ready_in=0: go to HELD.
- HELD → IDLE when ready_in=1, entry accepted using the buffer.
- ready_out:
  - Non-memory or excepted entry: ready_in.
  - Load/store: ready_in && (state==HELD || handshake this cycle).
- Load formatting:
  - Byte/half selected by addr_lsb_EX.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- rresp[1]=1 on a load: exc_pend_MEM=1, exc_cause_MEM=5 (load access fault), rd_wena_MEM=0.
- bresp[1]=1 on a store: exc_pend_MEM=1, exc_cause_MEM=7 (store access fault).
- Upstream exc_pend_EX passes through unchanged and takes priority.
- On acceptance, register all outputs; valid_out=1 one cycle later.
- Non-load entries: rd_data_MEM=rd_data_EX.
- When valid_out && ready_in and no new entry is accepted: valid_out←0 and rd_wena_MEM←0, so the bypass is never stale.
- flush:
  - Clears the MEM/WB register and valid_out, and state←IDLE.
  - If rd_outst or wr_outst is set and no response handshake occurs in that cycle, state←DRAIN.
  - DRAIN keeps ready_out=0 and discards the response. DRAIN→IDLE on the R/B handshake.
  - Flush in HELD drops the buffer.
- reset: all outputs 0, state IDLE, outstanding flags 0, rready=bready=0.

Test Plan:
- ALU entry with rd_data_EX=0x12345678, rd_addr=5, ready_in=1 → next cycle valid_out=1, rd_data_MEM=0x12345678, rd_wena_MEM=1.
- LB with addr_lsb=2 and rdata=0x0080FF00, R response 3 cycles after AR → ready_out stays 0 until rvalid; then rd_data_MEM=0xFFFFFF80. Repeat as LBU → 0x00000080.
- LH with addr_lsb=2, rvalid while ready_in=0 for 2 cycles → HELD. When ready_in rises, rd_data_MEM=0x00000080 and rready is not reasserted.
- Store SW with bresp=2'b10 → exc_pend_MEM=1, exc_cause_MEM=7, rd_wena_MEM=0.
- flush 1 cycle after AR handshake of a load, rvalid 2 cycles later → response discarded, no valid_out. A following ALU entry is stalled until the drain completes and then passes.
- reset asserted mid-HELD → all outputs 0 immediately, rready=0, state IDLE.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory AXI4-Lite signals seen by the memory stage. The stage only
// drives the R/B ready lines; the address channels are snooped so it knows
// which responses belong to accesses that are still in flight.
interface mem_stage_if;
    logic        arvalid;
    logic        arready;
    logic        awvalid;
    logic        awready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    // memory stage: snoops address handshakes, collects responses
    modport master (
        input  arvalid, arready, awvalid, awready,
        input  rdata, rresp, rvalid, bresp, bvalid,
        output rready, bready
    );

    // memory / interconnect side
    modport slave (
        input  arvalid, awvalid, rready, bready,
        output arready, awready, rdata, rresp, rvalid, bresp, bvalid
    );
endinterface

// File: rtl/mem_stage.sv
// RV32 memory stage: collects AXI4-Lite R/B responses for accesses issued by
// EX, formats load data, raises access faults and drives the MEM/WB register.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic [31:0] PC_EX,
    input  logic [31:0] IR_EX,
    input  logic        rd_wena_EX,
    input  logic [5:0]  rd_addr_EX,
    input  logic [31:0] rd_data_EX,
    input  logic [2:0]  wb_src_EX,
    input  logic [2:0]  mem_op_EX,
    input  logic [1:0]  addr_lsb_EX,
    input  logic        exc_pend_EX,
    input  logic [31:0] exc_cause_EX,
    mem_stage_if.master dmem_axi,
    output logic [31:0] PC_MEM,
    output logic [31:0] IR_MEM,
    output logic        rd_wena_MEM,
    output logic [5:0]  rd_addr_MEM,
    output logic [31:0] rd_data_MEM,
    output logic        exc_pend_MEM,
    output logic [31:0] exc_cause_MEM
);
    localparam logic [2:0]  SEL_MEM   = 3'd1;
    localparam logic [2:0]  MEM_LB    = 3'd0;
    localparam logic [2:0]  MEM_LH    = 3'd1;
    localparam logic [2:0]  MEM_LW    = 3'd2;
    localparam logic [2:0]  MEM_LBU   = 3'd3;
    localparam logic [2:0]  MEM_LHU   = 3'd4;
    localparam logic [31:0] CAUSE_LAF = 32'd5;
    localparam logic [31:0] CAUSE_SAF = 32'd7;

    typedef enum logic [1:0] {IDLE, HELD, DRAIN} state_t;

    state_t      state;
    logic        rd_outst, wr_outst;
    logic [31:0] resp_data;
    logic        resp_err;

    logic        is_mem, is_ld, is_st;
    logic        ar_hs, aw_hs, r_hs, b_hs, rsp_now, accept;
    logic        r_err, b_err, src_err;
    logic [31:0] src_data, shifted, ld_data;
    logic        nxt_wena, nxt_exc;
    logic [31:0] nxt_data, nxt_cause;

    // Excepted entries never touch memory, so they take the plain path.
    assign is_mem = valid_in && (wb_src_EX == SEL_MEM) && !exc_pend_EX;
    assign is_ld  = is_mem && rd_wena_EX;
    assign is_st  = is_mem && !rd_wena_EX;

    assign dmem_axi.rready = !reset && ((is_ld && state == IDLE) || state == DRAIN);
    assign dmem_axi.bready = !reset && ((is_st && state == IDLE) || state == DRAIN);

    assign ar_hs = dmem_axi.arvalid && dmem_axi.arready;
    assign aw_hs = dmem_axi.awvalid && dmem_axi.awready;
    assign r_hs  = dmem_axi.rvalid && dmem_axi.rready;
    assign b_hs  = dmem_axi.bvalid && dmem_axi.bready;
    assign r_err = dmem_axi.rresp >= 2'b10;
    assign b_err = dmem_axi.bresp >= 2'b10;

    // Response for the entry currently presented by EX arrives this cycle.
    assign rsp_now = (state == IDLE) && ((is_ld && r_hs) || (is_st && b_hs));

    // Accept when WB can take the entry and, for memory ops, the response is here.
    always_comb begin
        ready_out = 1'b0;
        if (state == DRAIN)
            ready_out = 1'b0;
        else if (is_mem)
            ready_out = ready_in && (state == HELD || rsp_now);
        else
            ready_out = ready_in;
    end

    assign accept = valid_in && ready_out;

    // Buffered response wins once captured; otherwise use the live channel.
    assign src_data = (state == HELD) ? resp_data : dmem_axi.rdata;
    assign src_err  = (state == HELD) ? resp_err : (is_ld ? r_err : b_err);
    assign shifted  = src_data >> {addr_lsb_EX, 3'b000};

    // Byte/half lane select with sign or zero extension.
    always_comb begin
        ld_data = src_data;
        case (mem_op_EX)
            MEM_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LH:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LW:  ld_data = src_data;
            MEM_LBU: ld_data = {24'd0, shifted[7:0]};
            MEM_LHU: ld_data = {16'd0, shifted[15:0]};
            default: ld_data = src_data;
        endcase
    end

    // Next MEM/WB contents; an upstream exception passes through untouched.
    always_comb begin
        nxt_data  = rd_data_EX;
        nxt_wena  = rd_wena_EX;
        nxt_exc   = exc_pend_EX;
        nxt_cause = exc_cause_EX;
        if (is_ld) begin
            nxt_data = ld_data;
            if (src_err) begin
                nxt_wena  = 1'b0;
                nxt_exc   = 1'b1;
                nxt_cause = CAUSE_LAF;
            end
        end else if (is_st && src_err) begin
            nxt_exc   = 1'b1;
            nxt_cause = CAUSE_SAF;
        end
    end

    // Track the single in-flight read and write seen on the address channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_outst <= 1'b0;
            wr_outst <= 1'b0;
        end else begin
            rd_outst <= (rd_outst && !r_hs) || ar_hs;
            wr_outst <= (wr_outst && !b_hs) || aw_hs;
        end
    end

    // Response FSM: hold a response while WB stalls, drain orphans after a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
        end else if (flush) begin
            // An access issued this cycle also leaves a response to discard.
            if ((rd_outst && !r_hs) || (wr_outst && !b_hs) || ar_hs || aw_hs)
                state <= DRAIN;
            else
                state <= IDLE;
        end else begin
            case (state)
                IDLE: if (rsp_now && !ready_in) begin
                    state     <= HELD;
                    resp_data <= dmem_axi.rdata;
                    resp_err  <= is_ld ? r_err : b_err;
                end
                HELD:  if (ready_in) state <= IDLE;
                DRAIN: if (r_hs || b_hs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // MEM/WB register; write enable drops on retirement so bypass never sees stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            valid_out     <= 1'b0;
            PC_MEM        <= 32'd0;
            IR_MEM        <= 32'd0;
            rd_wena_MEM   <= 1'b0;
            rd_addr_MEM   <= 6'd0;
            rd_data_MEM   <= 32'd0;
            exc_pend_MEM  <= 1'b0;
            exc_cause_MEM <= 32'd0;
        end else if (accept) begin
            valid_out     <= 1'b1;
            PC_MEM        <= PC_EX;
            IR_MEM        <= IR_EX;
            rd_wena_MEM   <= nxt_wena;
            rd_addr_MEM   <= rd_addr_EX;
            rd_data_MEM   <= nxt_data;
            exc_pend_MEM  <= nxt_exc;
            exc_cause_MEM <= nxt_cause;
        end else if (valid_out && ready_in) begin
            valid_out   <= 1'b0;
            rd_wena_MEM <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table of single transactions plus hand-written
// stall, drain and reset sequences; results checked through a scoreboard.
module tb_mem_stage;
    localparam logic [2:0] SEL_ALU = 3'd0;
    localparam logic [2:0] SEL_MEM = 3'd1;
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4, SW = 3'd7;
    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_EXC = 3;

    typedef struct {
        int          kind;
        logic [2:0]  op;
        logic [1:0]  lsb;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [31:0] rdx;
        logic [5:0]  rda;
        logic        exc;
        logic [31:0] cause;
        int          dly;
        logic [31:0] e_data;
        logic        e_wena;
        logic        e_exc;
        logic [31:0] e_cause;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [5:0]  addr;
        logic        wena;
        logic        exc;
        logic [31:0] cause;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic        valid_in = 1'b0, ready_in = 1'b1;
    logic        ready_out, valid_out;
    logic [31:0] PC_EX = '0, IR_EX = '0, rd_data_EX = '0, exc_cause_EX = '0;
    logic        rd_wena_EX = 1'b0, exc_pend_EX = 1'b0;
    logic [5:0]  rd_addr_EX = '0;
    logic [2:0]  wb_src_EX = '0, mem_op_EX = '0;
    logic [1:0]  addr_lsb_EX = '0;
    logic [31:0] PC_MEM, IR_MEM, rd_data_MEM, exc_cause_MEM;
    logic        rd_wena_MEM, exc_pend_MEM;
    logic [5:0]  rd_addr_MEM;

    mem_stage_if dmem_axi();

    mem_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_in(valid_in), .ready_out(ready_out), .valid_out(valid_out), .ready_in(ready_in),
        .PC_EX(PC_EX), .IR_EX(IR_EX), .rd_wena_EX(rd_wena_EX), .rd_addr_EX(rd_addr_EX),
        .rd_data_EX(rd_data_EX), .wb_src_EX(wb_src_EX), .mem_op_EX(mem_op_EX),
        .addr_lsb_EX(addr_lsb_EX), .exc_pend_EX(exc_pend_EX), .exc_cause_EX(exc_cause_EX),
        .dmem_axi(dmem_axi),
        .PC_MEM(PC_MEM), .IR_MEM(IR_MEM), .rd_wena_MEM(rd_wena_MEM), .rd_addr_MEM(rd_addr_MEM),
        .rd_data_MEM(rd_data_MEM), .exc_pend_MEM(exc_pend_MEM), .exc_cause_MEM(exc_cause_MEM)
    );

    always #5 clk = ~clk;

    int   n_chk = 0, n_err = 0;
    exp_t sb[$];
    exp_t cur_exp;
    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
        dmem_axi.arvalid = 1'b0; dmem_axi.arready = 1'b0;
        dmem_axi.awvalid = 1'b0; dmem_axi.awready = 1'b0;
        dmem_axi.rvalid  = 1'b0; dmem_axi.bvalid  = 1'b0;
    endtask

    task automatic drive(input vec_t v, input int idx);
        valid_in     = 1'b1;
        PC_EX        = 32'h100 + 32'(idx) * 4;
        IR_EX        = 32'hA000_0000 | 32'(idx);
        wb_src_EX    = (v.kind == K_ALU) ? SEL_ALU : SEL_MEM;
        rd_wena_EX   = (v.kind != K_ST);
        rd_addr_EX   = v.rda;
        rd_data_EX   = v.rdx;
        mem_op_EX    = v.op;
        addr_lsb_EX  = v.lsb;
        exc_pend_EX  = v.exc;
        exc_cause_EX = v.cause;
        cur_exp      = '{PC_EX, v.e_data, v.rda, v.e_wena, v.e_exc, v.e_cause};
    endtask

    // One transaction: address handshake, response after v.dly cycles, accept.
    task automatic run_vec(input vec_t v, input int idx);
        drive(v, idx);
        ready_in = 1'b1;
        if (v.kind == K_LD) begin dmem_axi.arvalid = 1'b1; dmem_axi.arready = 1'b1; end
        if (v.kind == K_ST) begin dmem_axi.awvalid = 1'b1; dmem_axi.awready = 1'b1; end
        #1;
        if (v.kind == K_LD || v.kind == K_ST) begin
            chk($sformatf("v%0d_wait_ready0", idx), 32'(ready_out), 32'd0);
            for (int i = 1; i < v.dly; i++) begin
                step();
                #1 chk($sformatf("v%0d_wait%0d_ready0", idx, i), 32'(ready_out), 32'd0);
            end
            step();
            if (v.kind == K_LD) begin
                dmem_axi.rvalid = 1'b1; dmem_axi.rdata = v.rdata; dmem_axi.rresp = v.resp;
                #1 chk($sformatf("v%0d_rready", idx), 32'(dmem_axi.rready), 32'd1);
            end else begin
                dmem_axi.bvalid = 1'b1; dmem_axi.bresp = v.resp;
                #1 chk($sformatf("v%0d_bready", idx), 32'(dmem_axi.bready), 32'd1);
            end
        end
        chk($sformatf("v%0d_ready_out", idx), 32'(ready_out), 32'd1);
        step();
        valid_in = 1'b0;
        step();
        step();
    endtask

    // Scoreboard: push on acceptance, pop when WB takes the MEM/WB entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid_out && ready_in) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid_out", 32'(valid_out), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pc_mem", PC_MEM, e.pc);
                    chk("rd_data_mem", rd_data_MEM, e.data);
                    chk("rd_addr_mem", 32'(rd_addr_MEM), 32'(e.addr));
                    chk("rd_wena_mem", 32'(rd_wena_MEM), 32'(e.wena));
                    chk("exc_pend_mem", 32'(exc_pend_MEM), 32'(e.exc));
                    chk("exc_cause_mem", exc_cause_MEM, e.cause);
                end
            end else if (!valid_out) begin
                chk("idle_wena0", 32'(rd_wena_MEM), 32'd0);
            end
            if (valid_in && ready_out && !flush) sb.push_back(cur_exp);
        end
    end

    initial begin
        vec_t alu2;
        dmem_axi.arvalid = 1'b0; dmem_axi.arready = 1'b0;
        dmem_axi.awvalid = 1'b0; dmem_axi.awready = 1'b0;
        dmem_axi.rvalid = 1'b0; dmem_axi.bvalid = 1'b0;
        dmem_axi.rdata = '0; dmem_axi.rresp = '0; dmem_axi.bresp = '0;

        vecs[0]  = '{K_ALU, LW,  2'd0, 32'h0,        2'b00, 32'h12345678, 6'd5,  1'b0, 32'd0, 0, 32'h12345678, 1'b1, 1'b0, 32'd0};
        vecs[1]  = '{K_LD,  LB,  2'd2, 32'h0080FF00, 2'b00, 32'h0,        6'd6,  1'b0, 32'd0, 3, 32'hFFFFFF80, 1'b1, 1'b0, 32'd0};
        vecs[2]  = '{K_LD,  LBU, 2'd2, 32'h0080FF00, 2'b00, 32'h0,        6'd6,  1'b0, 32'd0, 3, 32'h00000080, 1'b1, 1'b0, 32'd0};
        vecs[3]  = '{K_LD,  LW,  2'd0, 32'hDEADBEEF, 2'b00, 32'h0,        6'd8,  1'b0, 32'd0, 1, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0};
        vecs[4]  = '{K_LD,  LH,  2'd0, 32'h12348001, 2'b00, 32'h0,        6'd9,  1'b0, 32'd0, 2, 32'hFFFF8001, 1'b1, 1'b0, 32'd0};
        vecs[5]  = '{K_LD,  LHU, 2'd0, 32'h12348001, 2'b00, 32'h0,        6'd9,  1'b0, 32'd0, 2, 32'h00008001, 1'b1, 1'b0, 32'd0};
        vecs[6]  = '{K_LD,  LB,  2'd1, 32'h0000A500, 2'b00, 32'h0,        6'd33, 1'b0, 32'd0, 1, 32'hFFFFFFA5, 1'b1, 1'b0, 32'd0};
        vecs[7]  = '{K_LD,  LW,  2'd0, 32'h11111111, 2'b10, 32'h0,        6'd10, 1'b0, 32'd0, 1, 32'h11111111, 1'b0, 1'b1, 32'd5};
        vecs[8]  = '{K_ST,  SW,  2'd0, 32'h0,        2'b10, 32'h55AA55AA, 6'd0,  1'b0, 32'd0, 2, 32'h55AA55AA, 1'b0, 1'b1, 32'd7};
        vecs[9]  = '{K_ST,  SW,  2'd0, 32'h0,        2'b00, 32'h00000077, 6'd0,  1'b0, 32'd0, 1, 32'h00000077, 1'b0, 1'b0, 32'd0};
        vecs[10] = '{K_EXC, LW,  2'd0, 32'h0,        2'b00, 32'h00000099, 6'd11, 1'b1, 32'd2, 0, 32'h00000099, 1'b1, 1'b1, 32'd2};
        vecs[11] = '{K_LD,  LBU, 2'd3, 32'hAB000000, 2'b00, 32'h0,        6'd12, 1'b0, 32'd0, 1, 32'h000000AB, 1'b1, 1'b0, 32'd0};

        // reset state
        #12;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_rd_data", rd_data_MEM, 32'd0);
        chk("rst_wena", 32'(rd_wena_MEM), 32'd0);
        chk("rst_exc", 32'(exc_pend_MEM), 32'd0);
        chk("rst_rready", 32'(dmem_axi.rready), 32'd0);
        chk("rst_bready", 32'(dmem_axi.bready), 32'd0);
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // LH with WB stalled across the response: captured in the hold buffer
        drive('{K_LD, LH, 2'd2, 32'h0, 2'b00, 32'h0, 6'd7, 1'b0, 32'd0, 1, 32'h00000080, 1'b1, 1'b0, 32'd0}, 20);
        ready_in = 1'b0;
        dmem_axi.arvalid = 1'b1; dmem_axi.arready = 1'b1;
        step();
        dmem_axi.rvalid = 1'b1; dmem_axi.rdata = 32'h0080FF00; dmem_axi.rresp = 2'b00;
        #1 chk("held_rready_on_r", 32'(dmem_axi.rready), 32'd1);
        chk("held_ready_out_stall", 32'(ready_out), 32'd0);
        step();
        #1 chk("held_rready_off", 32'(dmem_axi.rready), 32'd0);
        chk("held_ready_out0", 32'(ready_out), 32'd0);
        step();
        ready_in = 1'b1;
        #1 chk("held_release_ready_out", 32'(ready_out), 32'd1);
        chk("held_release_rready", 32'(dmem_axi.rready), 32'd0);
        step();
        valid_in = 1'b0;
        step();
        step();

        // flush after a load's AR: response discarded, next ALU waits for drain
        drive(vecs[3], 21);
        dmem_axi.arvalid = 1'b1; dmem_axi.arready = 1'b1;
        step();
        valid_in = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        alu2 = '{K_ALU, LW, 2'd0, 32'h0, 2'b00, 32'hCAFEF00D, 6'd13, 1'b0, 32'd0, 0, 32'hCAFEF00D, 1'b1, 1'b0, 32'd0};
        drive(alu2, 22);
        #1 chk("drain_ready_out0", 32'(ready_out), 32'd0);
        chk("drain_rready", 32'(dmem_axi.rready), 32'd1);
        step();
        dmem_axi.rvalid = 1'b1; dmem_axi.rdata = 32'h0BAD0BAD; dmem_axi.rresp = 2'b00;
        #1 chk("drain_r_ready_out0", 32'(ready_out), 32'd0);
        chk("drain_valid_out0", 32'(valid_out), 32'd0);
        step();
        #1 chk("drain_done_ready_out", 32'(ready_out), 32'd1);
        step();
        valid_in = 1'b0;
        step();
        step();

        // reset while a response is held and WB is stalled
        run_vec(vecs[0], 23);
        drive(vecs[0], 24);
        step();
        drive(vecs[3], 25);
        ready_in = 1'b0;
        dmem_axi.arvalid = 1'b1; dmem_axi.arready = 1'b1;
        step();
        dmem_axi.rvalid = 1'b1; dmem_axi.rdata = 32'h12121212; dmem_axi.rresp = 2'b00;
        step();
        #1 chk("pre_reset_valid_out", 32'(valid_out), 32'd1);
        reset = 1'b1;
        #1 chk("mid_rst_valid_out", 32'(valid_out), 32'd0);
        chk("mid_rst_rd_data", rd_data_MEM, 32'd0);
        chk("mid_rst_pc", PC_MEM, 32'd0);
        chk("mid_rst_wena", 32'(rd_wena_MEM), 32'd0);
        chk("mid_rst_rready", 32'(dmem_axi.rready), 32'd0);
        chk("mid_rst_ready_out", 32'(ready_out), 32'd0);
        sb.delete();
        step();
        reset = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        step();
        run_vec(vecs[0], 26);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
